// File: rtl/axis_weight_preload.sv
// axis_weight_preload: packs S_AXIS_WIDTH beats LSB-first into WORD_W words and buffers them in a show-ahead FIFO.
// Latency: a word is visible on fifo_dout/fifo_cnt the cycle after its last-beat handshake.
// Backpressure: tready drops only on a word-completing beat while the FIFO is full; PRELOAD_TLAST_PAD_EN enables tlast zero-padding.
module axis_weight_preload #(
  parameter int MAC_NUM                 = 256,
  parameter int S_AXIS_WIDTH            = 64,
  parameter int AXIS_PRELOAD_FIFO_DEPTH = 4,
  parameter int bit_num                 = $clog2(AXIS_PRELOAD_FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [S_AXIS_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [5*MAC_NUM-1:0]      fifo_dout,
  input  logic                      fifo_read,
  output logic [bit_num:0]          fifo_cnt,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      tlast_misalign
);
  localparam int WORD_W = 5 * MAC_NUM;
  localparam int BEATS  = WORD_W / S_AXIS_WIDTH;
  localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DEPTH  = AXIS_PRELOAD_FIFO_DEPTH;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);
  localparam logic [bit_num:0] CNT_FULL = (bit_num + 1)'(DEPTH);

  logic [BC_W-1:0]    beat_cnt;
  logic [WORD_W-1:0]  pack_reg;
  logic [WORD_W-1:0]  push_word;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [bit_num-1:0] wr_ptr;
  logic [bit_num-1:0] rd_ptr;
  logic               word_end;
  logic               accept;
  logic               push;
  logic               pop;

`ifdef PRELOAD_TLAST_PAD_EN
  assign word_end = (beat_cnt == LAST_BEAT) || s_axis_tlast;
`else
  assign word_end = (beat_cnt == LAST_BEAT);
`endif

  assign fifo_full     = (fifo_cnt == CNT_FULL);
  assign fifo_empty    = (fifo_cnt == '0);
  assign s_axis_tready = !clear && !(word_end && fifo_full);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign push          = accept && word_end;
  assign pop           = fifo_read && !fifo_empty;
  assign fifo_dout     = mem[rd_ptr];

  // Slices above the current beat are zero so a padded tlast word needs no extra state.
  always_comb begin
    push_word = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (BC_W'(i) < beat_cnt)
        push_word[i*S_AXIS_WIDTH +: S_AXIS_WIDTH] = pack_reg[i*S_AXIS_WIDTH +: S_AXIS_WIDTH];
      else if (BC_W'(i) == beat_cnt)
        push_word[i*S_AXIS_WIDTH +: S_AXIS_WIDTH] = s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      pack_reg <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (accept) begin
      pack_reg[beat_cnt*S_AXIS_WIDTH +: S_AXIS_WIDTH] <= s_axis_tdata;
      beat_cnt <= word_end ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef PRELOAD_TLAST_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tlast_misalign <= 1'b0;
    else if (clear)
      tlast_misalign <= 1'b0;
    else if (accept && s_axis_tlast && (beat_cnt != LAST_BEAT))
      tlast_misalign <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast   = s_axis_tlast;
  assign tlast_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_axis_weight_preload.sv
// Randomized bench for axis_weight_preload with a queue-based word model and literal scenario checks.
module tb_axis_weight_preload;
  localparam int SW    = 64;
  localparam int BEATS = 20;
  localparam int DEPTH = 4;
  localparam int WW    = 1280;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [SW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [WW-1:0] fifo_dout;
  logic          fifo_read;
  logic [2:0]    fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          tlast_misalign;

  axis_weight_preload dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .fifo_dout      (fifo_dout),
    .fifo_read      (fifo_read),
    .fifo_cnt       (fifo_cnt),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .tlast_misalign (tlast_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: beats collected in an array, completed words kept in a queue.
  logic [SW-1:0] m_beats [BEATS];
  int            m_idx = 0;
  logic [WW-1:0] m_q [$];
  logic          m_mis = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      for (int s = 0; s < BEATS; s++) begin
        if (act[s*SW +: SW] !== exp[s*SW +: SW]) begin
          $display("FAIL %s: slice %0d got %0h expected %0h at %0t", name, s, act[s*SW +: SW], exp[s*SW +: SW], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic exp_rdy(input logic clr, input logic last);
    logic at_end;
    at_end = (m_idx == BEATS - 1);
`ifdef PRELOAD_TLAST_PAD_EN
    if (last) at_end = 1'b1;
`endif
    return !clr && !(at_end && m_q.size() == DEPTH);
  endfunction

  task automatic check_model(input logic clr, input logic last);
    chk("cnt", fifo_cnt, m_q.size());
    chk("empty", fifo_empty, m_q.size() == 0);
    chk("full", fifo_full, m_q.size() == DEPTH);
    chk("tready", s_axis_tready, exp_rdy(clr, last));
    chk("misalign", tlast_misalign, m_mis);
    if (m_q.size() > 0) chk_word("dout", fifo_dout, m_q[0]);
  endtask

  task automatic cyc(input logic v, input logic [SW-1:0] d, input logic l, input logic rd,
                     input logic clr, output logic acc);
    logic          pop;
    logic          end_w;
    logic [WW-1:0] w;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    fifo_read     = rd;
    clear         = clr;
    #1;
    check_model(clr, l);
    acc = v && exp_rdy(clr, l);
    pop = rd && (m_q.size() > 0);
    @(posedge clk);
    if (clr) begin
      m_q.delete();
      m_idx = 0;
      m_mis = 1'b0;
    end else begin
      if (pop) m_q.delete(0);
      if (acc) begin
        m_beats[m_idx] = d;
        end_w = (m_idx == BEATS - 1);
`ifdef PRELOAD_TLAST_PAD_EN
        if (l) begin
          end_w = 1'b1;
          if (m_idx != BEATS - 1) m_mis = 1'b1;
        end
`endif
        if (end_w) begin
          w = '0;
          for (int j = 0; j <= m_idx; j++) w[j*SW +: SW] = m_beats[j];
          m_q.push_back(w);
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    fifo_read     = 1'b0;
    clear         = 1'b0;
    #1;
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_misalign", tlast_misalign, 0);
    chk_word("rst_dout", fifo_dout, '0);
    m_q.delete();
    m_idx = 0;
    m_mis = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

  initial begin
    logic a;
    rst_n = 1'b0;
    clear = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    fifo_read     = 1'b0;
    do_reset();

    // One word of tdata=i.
    for (int i = 0; i < BEATS; i++) cyc(1, 64'(i), 0, 0, 0, a);
    chk("s1_cnt", fifo_cnt, 1);
    chk("s1_empty", fifo_empty, 0);
    for (int i = 0; i < BEATS; i++) chk("s1_slice", fifo_dout[SW*i +: SW], 64'(i));

    // Fill the FIFO, stall on the fifth word's last beat, then release with one pop.
    cyc(0, 0, 0, 0, 1, a);
    for (int b = 0; b < 100; b++) cyc(1, 64'h1000 + 64'(b), 0, 0, 0, a);
    chk("s2_cnt_full", fifo_cnt, 4);
    chk("s2_full", fifo_full, 1);
    chk("s2_stall", s_axis_tready, 0);
    cyc(1, 64'h1000 + 64'd99, 0, 1, 0, a);
    chk("s2_cnt_pop", fifo_cnt, 3);
    chk("s2_release", s_axis_tready, 1);
    cyc(1, 64'h1000 + 64'd99, 0, 0, 0, a);
    chk("s2_cnt_refill", fifo_cnt, 4);

    // Drain, read while empty, then a fresh word.
    for (int k = 0; k < 8 && m_q.size() > 0; k++) cyc(0, 0, 0, 1, 0, a);
    chk("s3_drained", fifo_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 0, a);
      chk("s3_empty_read", fifo_cnt, 0);
    end
    for (int i = 0; i < BEATS; i++) cyc(1, 64'h2000 + 64'(i), 0, 0, 0, a);
    chk("s3_cnt", fifo_cnt, 1);
    chk("s3_slice0", fifo_dout[63:0], 64'h2000);
    chk("s3_slice19", fifo_dout[SW*19 +: SW], 64'h2013);

    // Push and pop in the same cycle at cnt=2.
    for (int i = 0; i < BEATS; i++) cyc(1, 64'h3000 + 64'(i), 0, 0, 0, a);
    chk("s4_cnt2", fifo_cnt, 2);
    for (int i = 0; i < BEATS - 1; i++) cyc(1, 64'h4000 + 64'(i), 0, 0, 0, a);
    cyc(1, 64'h4013, 0, 1, 0, a);
    chk("s4_cnt_same", fifo_cnt, 2);
    chk("s4_dout_adv", fifo_dout[63:0], 64'h3000);

    // tlast on beat 7.
    cyc(0, 0, 0, 0, 1, a);
    for (int i = 0; i < 8; i++) cyc(1, 64'hA5, i == 7, 0, 0, a);
`ifdef PRELOAD_TLAST_PAD_EN
    chk("s5_cnt", fifo_cnt, 1);
    chk("s5_misalign", tlast_misalign, 1);
    for (int i = 0; i < BEATS; i++) chk("s5_pad_slice", fifo_dout[SW*i +: SW], (i <= 7) ? 64'hA5 : 64'h0);
`else
    chk("s5_nopush", fifo_cnt, 0);
    chk("s5_misalign", tlast_misalign, 0);
    for (int i = 0; i < 12; i++) cyc(1, 64'hA5, 0, 0, 0, a);
    chk("s5_word_done", fifo_cnt, 1);
    chk("s5_slice19", fifo_dout[SW*19 +: SW], 64'hA5);
`endif

    // Clear mid-word with cnt=3.
    cyc(0, 0, 0, 0, 1, a);
    for (int i = 0; i < 3 * BEATS + 10; i++) cyc(1, {$urandom, $urandom}, 0, 0, 0, a);
    chk("s6_cnt3", fifo_cnt, 3);
    cyc(0, 0, 0, 0, 1, a);
    chk("s6_clear_cnt", fifo_cnt, 0);
    for (int i = 0; i < BEATS; i++) cyc(1, 64'h100 + 64'(i), 0, 0, 0, a);
    chk("s6_cnt1", fifo_cnt, 1);
    chk("s6_slice0", fifo_dout[63:0], 64'h100);
    chk("s6_slice19", fifo_dout[SW*19 +: SW], 64'h113);

    // Reset mid-word with cnt=3.
    for (int i = 0; i < 2 * BEATS + 5; i++) cyc(1, {$urandom, $urandom}, 0, 0, 0, a);
    chk("s7_cnt3", fifo_cnt, 3);
    do_reset();
    for (int i = 0; i < BEATS; i++) cyc(1, 64'h500 + 64'(i), 0, 0, 0, a);
    chk("s7_cnt1", fifo_cnt, 1);
    chk("s7_slice0", fifo_dout[63:0], 64'h500);
    chk("s7_slice19", fifo_dout[SW*19 +: SW], 64'h513);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int rd_pct;
      rd_pct = (n < 1500) ? 6 : 2;
      if (n == 1500) do_reset();
      cyc($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < rd_pct, $urandom_range(0, 199) == 0, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/axis_weight_preload.md
# axis_weight_preload

Upstream stage of the weight-BRAM write path. Accepts a narrow AXI4-Stream of weight data, packs it beat by beat into full `5*MAC_NUM`-bit weight words, and buffers them in a small first-word-fall-through FIFO. The downstream BRAM controller reads the FIFO using a count/read interface: it samples `fifo_dout` in the same cycle it asserts `fifo_read`, and it may assert `fifo_read` while the FIFO is empty.

## Interface
- `MAC_NUM`, 256, number of MAC lanes; word width `WORD_W = 5*MAC_NUM`.
- `S_AXIS_WIDTH`, 64, input tdata width; `WORD_W` must be an exact multiple; `BEATS = WORD_W/S_AXIS_WIDTH` (20 at defaults).
- `AXIS_PRELOAD_FIFO_DEPTH`, 4, FIFO depth in words; power of two, ≥2.
- `bit_num`, `clogb2(AXIS_PRELOAD_FIFO_DEPTH-1)`, count MSB index.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous flush of FIFO, packer and error flag.
- `s_axis_tdata` in S_AXIS_WIDTH: input beat.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` out 1: beat accepted when high with tvalid.
- `s_axis_tlast` in 1: final beat of a layer transfer.
- `fifo_dout` out WORD_W: head word, show-ahead.
- `fifo_read` in 1: pop head at this edge; ignored when empty.
- `fifo_cnt` out bit_num+1: stored words, 0..DEPTH.
- `fifo_full` out 1: `fifo_cnt==DEPTH`.
- `fifo_empty` out 1: `fifo_cnt==0`.
- `tlast_misalign` out 1: sticky; tlast seen on a beat other than beat BEATS-1.

## Operation
- Packer: `beat_cnt` counts 0..BEATS-1. An accepted beat writes `pack_reg[beat_cnt*S_AXIS_WIDTH +: S_AXIS_WIDTH]` (LSB-first). On the accepted beat BEATS-1, the full word (current beat merged combinationally) is pushed into the FIFO and `beat_cnt` wraps to 0.
- `s_axis_tready = !clear && !(beat_cnt==BEATS-1 && fifo_full)`. The ready term does not look through a same-cycle `fifo_read`, so there is no combinational path from `fifo_read` to tready.
- FIFO: register array with `wr_ptr`/`rd_ptr` of width bit_num, wrapping modulo DEPTH, plus a registered `fifo_cnt`. `fifo_dout = mem[rd_ptr]` combinationally.
- Effective pop = `fifo_read && !fifo_empty`. Effective push = last-beat handshake.
- Push with no pop: cnt +1. Pop with no push: cnt −1. Push and pop together: cnt unchanged and both pointers advance.
- Push while full cannot occur, because tready gates it.
- `clear` has priority over push and pop. It zeroes both pointers, `fifo_cnt`, `beat_cnt` and `tlast_misalign`. Memory contents are kept.
- Reset: pointers, counts, `pack_reg` and `tlast_misalign` are 0, and memory is zeroed. Resulting outputs: `fifo_dout=0`, `fifo_cnt=0`, `fifo_empty=1`, `fifo_full=0`, `s_axis_tready=1`, `tlast_misalign=0`.

## Timing
- Last-beat handshake at edge N → `fifo_cnt`, `fifo_empty` and `fifo_dout` reflect the new word after edge N (visible in cycle N+1).
- Pop at edge N → the next word appears on `fifo_dout` in cycle N+1.
- Back-to-back pops in consecutive cycles are supported: the reader sees word k, then word k+1.
- Full throughput: one beat per cycle while not stalled.
- The tready stall is released one cycle after a pop that leaves the FIFO non-full.
- Reset asserted mid-word discards the partial word immediately; no spurious push occurs.

## Configuration
- `PRELOAD_TLAST_PAD_EN` defined:
  - An accepted tlast beat with `beat_cnt != BEATS-1` pushes the word with the remaining slices zero-filled, resets `beat_cnt` to 0 and sets `tlast_misalign`.
  - tready on such a beat also requires `!fifo_full`.
- `PRELOAD_TLAST_PAD_EN` undefined:
  - tlast is ignored for packing; words are formed strictly every BEATS beats.
  - `tlast_misalign` is tied to 0.

## Test plan
All scenarios use default parameters (BEATS=20, DEPTH=4).
- Send 20 beats with tdata=i for i=0..19 and no reads → one cycle later: `fifo_cnt=1`, `fifo_dout[64*i+:64]=i`, `fifo_empty=0`.
- Send 100 beats with no reads → `fifo_cnt=4`, `fifo_full=1`, tready low on the 5th word's beat 19. Pop once → tready high the next cycle, the word is pushed, and `fifo_cnt` settles at 4.
- Hold `fifo_read=1` for 3 cycles with `fifo_cnt=0` → `fifo_cnt` stays 0 and pointers are unchanged. A subsequent word is then read correctly.
- With `fifo_cnt=2`, complete a word and pop in the same cycle → `fifo_cnt` stays 2 and `fifo_dout` advances to the second word.
- tlast on beat 7 with data 0xA5 on all beats:
  - Macro on → pushed word has slices 0..7 = 0xA5, slices 8..19 = 0, and `tlast_misalign=1`.
  - Macro off → no push, and `beat_cnt=8`.
- Assert `clear` after beat 10, or drop `rst_n`, with `fifo_cnt=3` → `fifo_cnt=0` and the next 20 beats form a clean word 0. After `rst_n`, all outputs match their reset values.
